// File: rtl/io_port_bank.sv
// Memory-mapped GPIO bank: per-port data latch, direction register, input synchroniser,
// and change-detect interrupt with enable and write-1-to-clear status.
module io_port_bank #(
   parameter int unsigned WIDTH  = 8,
   parameter int unsigned NPORTS = 8,
   parameter int unsigned AW     = 8,
   parameter int unsigned ABASE  = 0
) (
   input  logic                      clk,
   input  logic                      rst_n,
   input  logic [AW-1:0]             addr,
   input  logic                      RE,
   input  logic                      WE,
   input  logic [WIDTH-1:0]          Din,
   output logic [WIDTH-1:0]          Dout,
   output logic                      io_read,
   output logic                      io_write,
   input  logic [NPORTS*WIDTH-1:0]   pin_in,
   output logic [NPORTS*WIDTH-1:0]   pin_out,
   output logic [NPORTS*WIDTH-1:0]   pin_oe,
   output logic                      irq
);

   localparam int unsigned PW   = NPORTS * WIDTH;
   localparam int unsigned NREG = 2 * NPORTS + 2;
   localparam logic [AW-1:0] ISR_OFF = AW'(2 * NPORTS);
   localparam logic [AW-1:0] IER_OFF = AW'(2 * NPORTS + 1);

   logic [PW-1:0]     latch_q, dir_q, s1_q, s2_q, s3_q;
   logic [NPORTS-1:0] isr_q, ier_q;
   logic [1:0]        arm_cnt_q;

   logic [AW:0]       diff_c;
   logic [AW-1:0]     off_c;
   logic              in_win_c;
   logic              armed_c;
   logic [WIDTH-1:0]  rd_c;
   logic [PW-1:0]     latch_d, dir_d;
   logic [NPORTS-1:0] isr_d, ier_d, w1c_c, chg_c;

   // Window decode; the extra bit catches addresses below ABASE without a constant compare.
   always_comb begin
      diff_c   = {1'b0, addr} - {1'b0, AW'(ABASE)};
      off_c    = diff_c[AW-1:0];
      in_win_c = !diff_c[AW] && (off_c < AW'(NREG));
   end

   assign io_read  = RE && in_win_c;
   assign io_write = WE && in_win_c;
   assign armed_c  = (arm_cnt_q == 2'd3);

   // Read mux, register updates and change detection.
   always_comb begin
      rd_c    = '0;
      latch_d = latch_q;
      dir_d   = dir_q;
      ier_d   = ier_q;
      w1c_c   = '0;
      chg_c   = '0;
      for (int unsigned k = 0; k < NPORTS; k++) begin
         if (off_c == AW'(k))
            rd_c = (latch_q[k*WIDTH +: WIDTH] & dir_q[k*WIDTH +: WIDTH]) |
                   (s2_q[k*WIDTH +: WIDTH] & ~dir_q[k*WIDTH +: WIDTH]);
         if (off_c == AW'(NPORTS + k))
            rd_c = dir_q[k*WIDTH +: WIDTH];
         if (io_write && (off_c == AW'(k)))
            latch_d[k*WIDTH +: WIDTH] = Din;
         if (io_write && (off_c == AW'(NPORTS + k)))
            dir_d[k*WIDTH +: WIDTH] = Din;
         // Output-configured bits never flag a change.
         chg_c[k] = |((s2_q[k*WIDTH +: WIDTH] ^ s3_q[k*WIDTH +: WIDTH]) &
                      ~dir_q[k*WIDTH +: WIDTH]);
      end
      if (off_c == ISR_OFF) rd_c = WIDTH'(isr_q);
      if (off_c == IER_OFF) rd_c = WIDTH'(ier_q);
      if (io_write && (off_c == ISR_OFF)) w1c_c = Din[NPORTS-1:0];
      if (io_write && (off_c == IER_OFF)) ier_d = Din[NPORTS-1:0];
      // Set wins over a same-cycle clear.
      isr_d = (isr_q & ~w1c_c) | (armed_c ? chg_c : '0);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         latch_q   <= '0;
         dir_q     <= '0;
         s1_q      <= '0;
         s2_q      <= '0;
         s3_q      <= '0;
         isr_q     <= '0;
         ier_q     <= '0;
         arm_cnt_q <= '0;
         Dout      <= '0;
      end else begin
         latch_q <= latch_d;
         dir_q   <= dir_d;
         isr_q   <= isr_d;
         ier_q   <= ier_d;
         s1_q    <= pin_in;
         s2_q    <= s1_q;
         s3_q    <= s2_q;
         // Hold off change detection until s3 holds real pad data.
         if (!armed_c) arm_cnt_q <= arm_cnt_q + 2'd1;
         if (RE) Dout <= io_read ? rd_c : '0;
      end
   end

   assign pin_out = latch_q;
   assign pin_oe  = dir_q;
   assign irq     = |(isr_q & ier_q);

endmodule

// File: tb/tb_io_port_bank.sv
// Directed bench for io_port_bank (WIDTH=8, NPORTS=8, ABASE=0x10) with a read-data scoreboard.
module tb_io_port_bank;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [7:0]  addr;
   logic        RE, WE;
   logic [7:0]  Din;
   logic [7:0]  Dout;
   logic        io_read, io_write;
   logic [63:0] pin_in, pin_out, pin_oe;
   logic        irq;

   int checks = 0;
   int errors = 0;
   logic [7:0] exp_q[$];
   string      tag_q[$];

   io_port_bank #(.WIDTH(8), .NPORTS(8), .AW(8), .ABASE(8'h10)) dut (
      .clk(clk), .rst_n(rst_n), .addr(addr), .RE(RE), .WE(WE), .Din(Din), .Dout(Dout),
      .io_read(io_read), .io_write(io_write), .pin_in(pin_in), .pin_out(pin_out),
      .pin_oe(pin_oe), .irq(irq)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // One bus cycle; read results are queued at drive time and compared once Dout updates.
   task automatic bus(input logic [7:0] a, input logic re, input logic we,
                      input logic [7:0] d, input logic [7:0] exp, input string tag);
      @(negedge clk);
      addr = a; RE = re; WE = we; Din = d;
      if (re) begin
         exp_q.push_back(exp);
         tag_q.push_back(tag);
      end
      @(posedge clk); #1;
      RE = 1'b0; WE = 1'b0;
      if (re) check(tag_q.pop_front(), 64'(Dout), 64'(exp_q.pop_front()));
   endtask

   task automatic wr(input logic [7:0] a, input logic [7:0] d);
      bus(a, 1'b0, 1'b1, d, 8'h00, "");
   endtask

   task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string tag);
      bus(a, 1'b1, 1'b0, 8'h00, exp, tag);
   endtask

   initial begin
      rst_n = 1'b0; addr = '0; RE = 1'b0; WE = 1'b0; Din = '0;
      pin_in = 64'h0000_0000_003C_0000;
      #12;
      check("rst_dout", 64'(Dout), 64'h0);
      check("rst_oe", pin_oe, 64'h0);
      check("rst_out", pin_out, 64'h0);
      check("rst_irq", 64'(irq), 64'h0);
      @(negedge clk); rst_n = 1'b1;
      repeat (4) @(posedge clk);
      rd(8'h20, 8'h00, "isr_after_rst");

      // Mixed-direction port read-back.
      wr(8'h1A, 8'hF0);
      wr(8'h12, 8'hA5);
      check("p2_out", 64'(pin_out[23:16]), 64'hA5);
      check("p2_oe", 64'(pin_oe[23:16]), 64'hF0);
      rd(8'h12, 8'hAC, "p2_mixed_read");

      // Input change on port 3 raises ISR and irq two edges after sampling.
      wr(8'h21, 8'h08);
      wr(8'h1B, 8'h00);
      @(negedge clk); pin_in[24] = ~pin_in[24];
      @(posedge clk);
      @(posedge clk); #1 check("irq_e1", 64'(irq), 64'h0);
      @(posedge clk); #1 check("irq_e2", 64'(irq), 64'h1);
      rd(8'h20, 8'h08, "isr_p3");
      wr(8'h20, 8'h08);
      check("irq_cleared", 64'(irq), 64'h0);
      @(negedge clk); pin_in[23] = ~pin_in[23];
      repeat (4) @(posedge clk);
      rd(8'h20, 8'h00, "isr_output_bit");

      // W1C racing a new change on the same port: set wins.
      @(negedge clk); pin_in[24] = ~pin_in[24];
      repeat (4) @(posedge clk);
      @(negedge clk); pin_in[25] = ~pin_in[25];
      @(posedge clk);
      @(posedge clk);
      wr(8'h20, 8'h08);
      rd(8'h20, 8'h08, "isr_race");
      wr(8'h20, 8'h08);
      rd(8'h20, 8'h00, "isr_w1c");
      check("irq_w1c", 64'(irq), 64'h0);

      // Simultaneous read and write returns the pre-write value.
      wr(8'h1A, 8'hFF);
      wr(8'h12, 8'h55);
      bus(8'h12, 1'b1, 1'b1, 8'h0F, 8'h55, "rw_old");
      rd(8'h12, 8'h0F, "rw_new");
      check("rw_pin", 64'(pin_out[23:16]), 64'h0F);

      // Window boundaries and out-of-window accesses.
      @(negedge clk); addr = 8'h05; RE = 1'b1;
      #1 check("ioread_below", 64'(io_read), 64'h0);
      @(posedge clk); #1 RE = 1'b0;
      check("dout_below", 64'(Dout), 64'h0);
      @(negedge clk); addr = 8'h21; RE = 1'b1;
      #1 check("ioread_top", 64'(io_read), 64'h1);
      RE = 1'b0;
      rd(8'h21, 8'h08, "ier_read");
      rd(8'h22, 8'h00, "read_above");
      @(negedge clk); addr = 8'h22; WE = 1'b1; Din = 8'hFF;
      #1 check("iowrite_above", 64'(io_write), 64'h0);
      @(posedge clk); #1 WE = 1'b0;
      check("oe_after_oow", pin_oe, 64'h0000_0000_00FF_0000);
      rd(8'h21, 8'h08, "ier_after_oow");

      // Reset mid-write, then no spurious ISR during the arm-up window.
      @(negedge clk); pin_in[24] = ~pin_in[24];
      repeat (4) @(posedge clk);
      #1 check("irq_pre_rst", 64'(irq), 64'h1);
      @(negedge clk); addr = 8'h12; WE = 1'b1; Din = 8'hAA;
      #2 rst_n = 1'b0;
      #1;
      check("mid_rst_oe", pin_oe, 64'h0);
      check("mid_rst_out", pin_out, 64'h0);
      check("mid_rst_irq", 64'(irq), 64'h0);
      check("mid_rst_dout", 64'(Dout), 64'h0);
      WE = 1'b0;
      pin_in = 64'hFFEE_DDCC_BBAA_9988;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      wr(8'h21, 8'hFF);
      for (int i = 0; i < 5; i++) begin
         @(posedge clk); #1 check("irq_arm", 64'(irq), 64'h0);
      end
      rd(8'h20, 8'h00, "isr_arm");
      check("out_after_rst", pin_out, 64'h0);
      @(negedge clk); pin_in[0] = ~pin_in[0];
      repeat (4) @(posedge clk);
      #1 check("irq_rearmed", 64'(irq), 64'h1);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/io_port_bank.md
# io_port_bank

Parametrised, clocked memory-mapped GPIO bank for the CPU data bus. It exposes NPORTS ports of WIDTH bits, each with a per-bit direction register, an output latch and a two-flop input synchroniser. Per-port change detection drives an interrupt with enable and write-1-to-clear status. It replaces the fixed 8×8 combinational tri-state port decoder and sits on the same addr/RE/WE/Din/Dout bus; pad tri-states are moved to the top level.

## Interface
- WIDTH, 8, data and port width in bits
- NPORTS, 8, number of ports; must be 1..WIDTH
- AW, 8, address width
- ABASE, 0, base address of the bank; must be aligned so the window ABASE..ABASE+2*NPORTS+1 does not wrap

- clk  in  1  system clock; all state updates on the rising edge
- rst_n  in  1  asynchronous, active-low reset
- addr  in  AW  bus address
- RE  in  1  read strobe, one cycle per access
- WE  in  1  write strobe, one cycle per access
- Din  in  WIDTH  write data
- Dout  out  WIDTH  registered read data
- io_read  out  1  combinational: RE and addr inside the window
- io_write  out  1  combinational: WE and addr inside the window
- pin_in  in  NPORTS*WIDTH  pad inputs; port k occupies bits [k*WIDTH +: WIDTH]; asynchronous
- pin_out  out  NPORTS*WIDTH  output latches
- pin_oe  out  NPORTS*WIDTH  per-bit output enables; 1 = drive
- irq  out  1  interrupt request, level

## Operation
- Register map, offset from ABASE:
  - k (0..NPORTS-1): DATA[k]
  - NPORTS+k: DIR[k]
  - 2*NPORTS: ISR, bit k = change seen on port k
  - 2*NPORTS+1: IER, bit k enables port k
- ISR and IER bits at index NPORTS and above read as 0 and ignore writes.
- DATA write: loads the output latch for all bits, including bits currently configured as inputs.
- DATA read: per bit, DIR=1 returns the latch value; DIR=0 returns the synchronised input.
- DIR write and read: plain register. pin_oe = DIR and pin_out = latch, both driven directly from flops.
- Synchroniser chain per bit: s1 <= pin_in, s2 <= s1, s3 <= s2. Change on port k = OR over bits of (s2^s3) masked by ~DIR, so output bits never flag.
- ISR[k] is set on a change and cleared by writing 1 to that bit. Writing 0 has no effect.
- When a set and a clear hit the same cycle, set wins.
- irq = OR(ISR & IER), combinational from flops, no other logic.
- Reads and writes outside the window: Dout <= 0, no state change, io_read and io_write stay 0.
- RE and WE asserted in the same cycle at the same address:
  - Write is performed.
  - Dout returns the pre-write value.
  - A W1C on ISR does not clear the value being returned.
- Reset (asynchronous, any time, including mid-access):
  - Latches, DIR (all inputs), ISR, IER, s1..s3 and Dout go to 0.
  - pin_oe = 0 and irq = 0 immediately.
  - An access in flight is dropped.
  - The first change detection after reset release needs s3 filled, so no spurious ISR set from the reset zeros: ISR setting is inhibited for the first 3 cycles after rst_n rises, using a 2-bit counter.

## Timing
- Write sampled at edge E: latch, DIR or IER visible on pin_out, pin_oe or irq after E.
- Read sampled at edge E: Dout valid after E, one-cycle latency. Dout holds its value until the next RE; WE alone does not change Dout.
- Back-to-back accesses are allowed every cycle. No wait states.
- Input latency: pin_in stable before edge E0 gives:
  - s2 new after E1
  - a DATA read sampled at E2 returns the new value
  - ISR set after E2
  - irq high after E2 if enabled
- A pulse must be held across at least 2 edges to be guaranteed seen.
- Enabling IER while ISR is already set raises irq right after the write edge.

## Test plan
- Reset, WIDTH=8, NPORTS=8, ABASE=0x10: after reset, Dout=0, pin_oe=0, pin_out=0, irq=0. Read 0x20 (ISR) returns 0x00.
- Write DIR[2] (0x1A)=0xF0, then DATA[2] (0x12)=0xA5, with pin_in port 2 = 0x3C:
  - pin_out[23:16]=0xA5 and pin_oe[23:16]=0xF0.
  - Read 0x12 returns 0xAC.
- IER (0x21)=0x08, DIR[3]=0x00, toggle pin_in port 3 bit 0 at E0:
  - ISR=0x08 and irq=1 after E2.
  - Toggle an output bit instead: no ISR change.
- W1C race: write ISR=0x08 in the same cycle port 3 detects a new change -> ISR stays 0x08. Next write of 0x08 with no change -> ISR=0x00, irq=0.
- Simultaneous RE+WE to 0x12 with old latch 0x55 and Din 0x0F (DIR=0xFF) -> Dout=0x55, next read 0x0F.
- Out-of-window access: read 0x05 or 0x22 -> Dout=0, io_read=0. Write 0x22 -> no register changes.
- Assert rst_n low mid-write -> all outputs 0 immediately. No ISR set within 3 cycles of release even with pin_in ≠ 0.
